// File: rtl/sam_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared SAM memory.
// Port 0 (CPU) can lock out port 1 (front panel) while it was the last owner.
module sam_mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          last_owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state, state_d;
    logic [1:0] cnt, cnt_d;
    logic       we_q;
    logic       owner_d;
    logic       m1_elig;
    logic       start;
    logic       capture;
    logic       sel_we;

    // last_owner doubles as the current owner from ISSUE through ACK.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        owner_d = last_owner;
        start   = 1'b0;
        capture = 1'b0;
        m1_elig = m1_req && !(m0_lock && !last_owner);
        case (state)
            IDLE: begin
                if (m0_req || m1_elig) begin
                    start   = 1'b1;
                    state_d = ISSUE;
                    if (m0_req && m1_elig) owner_d = ~last_owner;
                    else                   owner_d = m1_elig;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt - 2'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sel_we = owner_d ? m1_we : m0_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            we_q       <= 1'b0;
            last_owner <= 1'b1;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            // Latch the winner's request; the memory bus registers hold it while idle.
            if (start) begin
                last_owner <= owner_d;
                we_q       <= sel_we;
                mem_addr   <= owner_d ? m1_addr  : m0_addr;
                mem_wdata  <= owner_d ? m1_wdata : m0_wdata;
            end
            mem_en <= start;
            mem_we <= start && sel_we;
            m0_gnt <= (state_d != IDLE) && !owner_d;
            m1_gnt <= (state_d != IDLE) &&  owner_d;
            m0_ack <= (state_d == ACK)  && !owner_d;
            m1_ack <= (state_d == ACK)  &&  owner_d;
            busy   <= (state_d != IDLE);
            if (capture) begin
                if (last_owner) m1_rdata <= mem_rdata;
                else            m0_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// Directed bench for sam_mem_arbiter with RD_LAT=2 and a behavioural memory
// whose contents after reset are addr ^ 8'h1C (so 8'h20 holds 8'h3C).
module tb_sam_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, last_owner;

    int n_chk = 0;
    int n_fail = 0;

    sam_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .last_owner(last_owner)
    );

    always #5 clk = ~clk;

    // Memory: read data appears RD_LAT (=2) cycles after the mem_en cycle.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_p1;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1C;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_en) rd_p1 <= mem[mem_addr];
        mem_rdata <= rd_p1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until an ISSUE cycle (mem_en high), bounded.
    task automatic wait_issue(output int n);
        n = 0;
        while (mem_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("issue_seen", {31'd0, mem_en}, 32'd1);
    endtask

    int n, acks;

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 0);
        chk("rst_last_owner", {31'd0, last_owner}, 1);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_rdata", {16'd0, m1_rdata, m0_rdata}, 0);

        // m0 write 5A -> 10
        rst = 0;
        m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 8'h5A;
        tick();
        chk("w_issue_en_we", {30'd0, mem_en, mem_we}, 32'h3);
        chk("w_issue_addr", {24'd0, mem_addr}, 32'h10);
        chk("w_issue_data", {24'd0, mem_wdata}, 32'h5A);
        chk("w_issue_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h1);
        chk("w_issue_noack", {31'd0, m0_ack}, 0);
        tick();
        chk("w_ack", {30'd0, m1_ack, m0_ack}, 32'h1);
        chk("w_ack_en", {31'd0, mem_en}, 0);
        chk("w_mem", {24'd0, mem[8'h10]}, 32'h5A);
        m0_req = 0;
        tick();
        chk("w_idle", {29'd0, busy, m0_ack, m0_gnt}, 0);

        // m1 read 20 (holds 3C)
        m1_req = 1; m1_we = 0; m1_addr = 8'h20;
        tick();
        chk("r_issue", {29'd0, mem_en, mem_we, m1_gnt}, 32'h5);
        tick(); tick();
        chk("r_noack_early", {31'd0, m1_ack}, 0);
        tick();
        chk("r_ack", {30'd0, m1_ack, m0_ack}, 32'h2);
        chk("r_rdata", {24'd0, m1_rdata}, 32'h3C);
        m1_req = 0;
        tick();
        chk("r_ack_drop", {31'd0, m1_ack}, 0);
        chk("r_rdata_hold", {24'd0, m1_rdata}, 32'h3C);

        // Round-robin from reset with both requesting
        rst = 1; tick(); rst = 0;
        m0_req = 1; m0_we = 1; m0_addr = 8'h30; m0_wdata = 8'h11;
        m1_req = 1; m1_we = 1; m1_addr = 8'h31; m1_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            wait_issue(n);
            chk("rr_gap", n, (i == 0) ? 32'd1 : 32'd2);
            chk("rr_owner", {30'd0, m1_gnt, m0_gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_addr", {24'd0, mem_addr}, (i % 2 == 0) ? 32'h30 : 32'h31);
        end
        tick();
        m0_req = 0; m1_req = 0;
        tick();

        // Lock: m0 keeps the memory until lock drops
        rst = 1; tick(); rst = 0;
        m0_lock = 1; m0_req = 1; m1_req = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            wait_issue(n);
            chk("lock_owner", {30'd0, m1_gnt, m0_gnt}, 32'h1);
        end
        m0_lock = 0;
        tick();
        wait_issue(n);
        chk("unlock_owner", {30'd0, m1_gnt, m0_gnt}, 32'h2);
        tick();
        m0_req = 0; m1_req = 0;
        tick();
        chk("unlock_idle", {31'd0, busy}, 0);

        // Reset during a read WAIT
        rst = 1; tick(); rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 8'h20;
        wait_issue(n);
        tick(); tick(); tick();
        chk("r0_ack", {31'd0, m0_ack}, 1);
        chk("r0_rdata", {24'd0, m0_rdata}, 32'h3C);
        m0_req = 0;
        tick();
        m0_req = 1; m0_addr = 8'h21;
        tick();
        chk("r0b_issue", {31'd0, mem_en}, 1);
        tick();
        chk("r0b_wait_busy", {31'd0, busy}, 1);
        rst = 1; m0_req = 0;
        tick();
        chk("abort_busy_en", {30'd0, busy, mem_en}, 0);
        chk("abort_gnt_ack", {30'd0, m0_gnt, m0_ack}, 0);
        chk("abort_rdata", {24'd0, m0_rdata}, 0);
        chk("abort_last_owner", {31'd0, last_owner}, 1);
        rst = 0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m0_ack === 1'b1) acks++;
        end
        chk("abort_no_ack", acks, 0);
        m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
        wait_issue(n);
        chk("abort_tie_m0", {30'd0, m1_gnt, m0_gnt}, 32'h1);
        tick();
        m0_req = 0; m1_req = 0;
        tick();

        // Address change after latching has no effect
        m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 8'h77;
        wait_issue(n);
        chk("lat_issue_addr", {24'd0, mem_addr}, 32'h10);
        m0_addr = 8'h11;
        tick();
        chk("lat_ack", {31'd0, m0_ack}, 1);
        chk("lat_hold_addr", {24'd0, mem_addr}, 32'h10);
        chk("lat_mem10", {24'd0, mem[8'h10]}, 32'h77);
        m0_req = 0;
        tick();
        m0_req = 1;
        wait_issue(n);
        chk("lat_next_addr", {24'd0, mem_addr}, 32'h11);
        tick();
        m0_req = 0;
        tick();
        chk("lat_mem11", {24'd0, mem[8'h11]}, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
